// File: rtl/wb_port_arbiter.sv
// Two-requester register-file write-port arbiter with registered write outputs.
// Build option WB_ARB_RR_EN: round-robin tie-break; undefined gives fixed A priority.
module wb_port_arbiter #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          sel
);

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

    req_e          last_q;
    req_e          last_d;
    logic          grant_a;
    logic          grant_b;
    logic          tie_to_b;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;

    // Tie resolution; the fixed-priority build still tracks last but never consults it.
    always_comb begin
        tie_to_b = 1'b0;
`ifdef WB_ARB_RR_EN
        tie_to_b = (last_q == REQ_A);
`endif
    end

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        last_d  = last_q;
        if (!rst && !stall) begin
            if (a_valid && b_valid) begin
                grant_a = !tie_to_b;
                grant_b = tie_to_b;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
        if (grant_a) begin
            last_d = REQ_A;
        end else if (grant_b) begin
            last_d = REQ_B;
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign win_addr = grant_b ? b_addr : a_addr;
    assign win_data = grant_b ? b_data : a_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= REQ_B;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            sel     <= 1'b0;
        end else begin
            last_q <= last_d;
            wr_en  <= 1'b0;
            if (grant_a || grant_b) begin
                // Writes to register 0 are consumed without a strobe.
                wr_en   <= |win_addr;
                wr_addr <= win_addr;
                wr_data <= win_data;
                sel     <= grant_b;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vectors, a behavioural
// model compared every cycle, and hand-computed literal expectations.
module tb_wb_port_arbiter;

`ifdef WB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        wr_en, sel;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    wb_port_arbiter #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sel(sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: which requester wins this cycle, {b,a}; last is 0 for A, 1 for B.
    function automatic logic [1:0] pick(input logic rs, input logic st,
                                        input logic av, input logic bv, input logic lst);
        if (rs || st || (!av && !bv)) return 2'b00;
        if (av && !bv) return 2'b01;
        if (bv && !av) return 2'b10;
        if (RR && !lst) return 2'b10;
        return 2'b01;
    endfunction

    logic        m_ok = 1'b0;
    logic        m_last, m_wr_en, m_sel;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    always @(posedge clk) begin
        logic [1:0] g;
        g = pick(rst, stall, a_valid, b_valid, m_last);
        if (rst) begin
            m_ok    <= 1'b1;
            m_last  <= 1'b1;
            m_wr_en <= 1'b0;
            m_addr  <= 5'd0;
            m_data  <= 32'd0;
            m_sel   <= 1'b0;
        end else if (g == 2'b01) begin
            m_last  <= 1'b0;
            m_wr_en <= (a_addr != 5'd0);
            m_addr  <= a_addr;
            m_data  <= a_data;
            m_sel   <= 1'b0;
        end else if (g == 2'b10) begin
            m_last  <= 1'b1;
            m_wr_en <= (b_addr != 5'd0);
            m_addr  <= b_addr;
            m_data  <= b_data;
            m_sel   <= 1'b1;
        end else begin
            m_wr_en <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            logic [1:0] g;
            g = pick(rst, stall, a_valid, b_valid, m_last);
            check("model a_ready", {31'd0, a_ready}, {31'd0, g[0]});
            check("model b_ready", {31'd0, b_ready}, {31'd0, g[1]});
            check("model wr_en",   {31'd0, wr_en},   {31'd0, m_wr_en});
            check("model wr_addr", {27'd0, wr_addr}, {27'd0, m_addr});
            check("model wr_data", wr_data, m_data);
            check("model sel",     {31'd0, sel},     {31'd0, m_sel});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rs, input logic st,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        rst = rs; stall = st;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
    endtask

    initial begin
        logic [4:0] exp_addr;
        drive(1, 0, 1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'hBBBB_0007);

        // Reset held two cycles with both requesters valid.
        for (int i = 0; i < 2; i++) begin
            check("rst a_ready", {31'd0, a_ready}, 32'd0);
            check("rst b_ready", {31'd0, b_ready}, 32'd0);
            tick;
            check("rst wr_en",   {31'd0, wr_en}, 32'd0);
            check("rst sel",     {31'd0, sel},   32'd0);
            check("rst wr_addr", {27'd0, wr_addr}, 32'd0);
            check("rst wr_data", wr_data, 32'd0);
        end

        // Continuous dual request: RR alternates from A, fixed priority always A.
        drive(0, 0, 1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'hBBBB_0007);
        for (int i = 0; i < 4; i++) begin
            check("dual a_ready", {31'd0, a_ready}, (RR && i[0]) ? 32'd0 : 32'd1);
            check("dual b_ready", {31'd0, b_ready}, (RR && i[0]) ? 32'd1 : 32'd0);
            tick;
            exp_addr = (RR && i[0]) ? 5'd7 : 5'd3;
            check("dual wr_addr", {27'd0, wr_addr}, {27'd0, exp_addr});
            check("dual sel", {31'd0, sel}, (RR && i[0]) ? 32'd1 : 32'd0);
            check("dual wr_en", {31'd0, wr_en}, 32'd1);
        end

        // A alone.
        drive(0, 0, 1, 5'd5, 32'h1234_5678, 0, 5'd7, 32'hBBBB_0007);
        check("aonly a_ready", {31'd0, a_ready}, 32'd1);
        check("aonly b_ready", {31'd0, b_ready}, 32'd0);
        tick;
        check("aonly wr_en",   {31'd0, wr_en}, 32'd1);
        check("aonly wr_addr", {27'd0, wr_addr}, 32'd5);
        check("aonly wr_data", wr_data, 32'h1234_5678);
        check("aonly sel",     {31'd0, sel}, 32'd0);

        // B writes $0: accepted, no strobe, sel and last still move to B.
        drive(0, 0, 0, 5'd5, 32'h1234_5678, 1, 5'd0, 32'hFFFF_FFFF);
        check("zero b_ready", {31'd0, b_ready}, 32'd1);
        tick;
        check("zero wr_en",   {31'd0, wr_en}, 32'd0);
        check("zero sel",     {31'd0, sel}, 32'd1);
        check("zero wr_addr", {27'd0, wr_addr}, 32'd0);
        check("zero wr_data", wr_data, 32'hFFFF_FFFF);

        // Following tie goes to A in both builds.
        drive(0, 0, 1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'hBBBB_0007);
        check("tie a_ready", {31'd0, a_ready}, 32'd1);
        tick;
        check("tie wr_en",   {31'd0, wr_en}, 32'd1);
        check("tie wr_addr", {27'd0, wr_addr}, 32'd3);

        // Stall three cycles after that A grant.
        drive(0, 1, 1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'hBBBB_0007);
        for (int i = 0; i < 3; i++) begin
            check("stall a_ready", {31'd0, a_ready}, 32'd0);
            check("stall b_ready", {31'd0, b_ready}, 32'd0);
            tick;
            check("stall wr_en", {31'd0, wr_en}, 32'd0);
            check("stall wr_addr", {27'd0, wr_addr}, 32'd3);
        end
        drive(0, 0, 1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'hBBBB_0007);
        check("release b_ready", {31'd0, b_ready}, RR ? 32'd1 : 32'd0);
        check("release a_ready", {31'd0, a_ready}, RR ? 32'd0 : 32'd1);
        tick;
        check("release sel",     {31'd0, sel}, RR ? 32'd1 : 32'd0);
        check("release wr_addr", {27'd0, wr_addr}, RR ? 32'd7 : 32'd3);

        // Reset pulsed the cycle after an A grant.
        drive(0, 0, 1, 5'd9, 32'hDEAD_BEEF, 0, 5'd7, 32'hBBBB_0007);
        tick;
        check("pre-rst wr_en", {31'd0, wr_en}, 32'd1);
        check("pre-rst wr_data", wr_data, 32'hDEAD_BEEF);
        drive(1, 0, 1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'hBBBB_0007);
        check("midrst a_ready", {31'd0, a_ready}, 32'd0);
        check("midrst b_ready", {31'd0, b_ready}, 32'd0);
        tick;
        check("midrst wr_en",   {31'd0, wr_en}, 32'd0);
        check("midrst wr_addr", {27'd0, wr_addr}, 32'd0);
        drive(0, 0, 1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'hBBBB_0007);
        check("postrst a_ready", {31'd0, a_ready}, 32'd1);
        tick;
        check("postrst sel",     {31'd0, sel}, 32'd0);
        check("postrst wr_addr", {27'd0, wr_addr}, 32'd3);

        // Mixed traffic checked by the model only; address 0 kept frequent.
        for (int i = 0; i < 80; i++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0),
                  1'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
                  1'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom);
            tick;
        end

        drive(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        tick;
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
